// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Single-clock 32-bit data RAM (2^AW words) shared between a
//                CPU port and a host port. The CPU normally owns the RAM. A
//                host takes exclusive ownership by raising host_mode. The
//                handover runs CPU -> DRAIN -> HOST, and the return runs
//                HOST -> RELEASE -> CPU.
//
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                wr_enable           - CPU write strobe
//                cpu_addr, cpu_data  - CPU word address / write data
//                mem_data            - registered CPU read data (latency 1)
//                host_mode           - host requests ownership
//                host_gnt            - host currently owns the RAM
//                host_req, host_we   - host access strobe / write select
//                host_addr           - host word address (RAM-relative)
//                host_wdata          - host write data
//                host_rdata          - host read data
//                host_valid          - one-cycle pulse, host_rdata valid
//                err                 - sticky error flag
//
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int unsigned AW   = 10,
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_enable,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_data,
    output logic [31:0]   mem_data,
    input  logic          host_mode,
    output logic          host_gnt,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    output logic [31:0]   host_rdata,
    output logic          host_valid,
    output logic          err
);

    localparam int unsigned c_DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        S_CPU     = 2'd0,
        S_DRAIN   = 2'd1,
        S_HOST    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_cpu_service;
    logic          w_host_own;

    logic [31:0]   r_mem [c_DEPTH];
    logic [31:0]   r_mem_data;
    logic [31:0]   r_host_rdata;
    logic          r_host_valid;
    logic          r_err;

    logic [31:0]   w_offset;
    logic          w_cpu_in_range;
    logic [AW-1:0] w_cpu_idx;
    logic          w_cpu_write;
    logic          w_host_write;
    logic          w_host_read;
    logic          w_err_set;

    // Unsigned subtraction wraps for addresses below BASE, which pushes the
    // offset far above 2^AW. The single upper-bits test therefore rejects both
    // addresses below BASE and addresses past the end of the RAM.
    assign w_offset       = cpu_addr - BASE;
    assign w_cpu_in_range = (w_offset[31:AW] == '0);
    assign w_cpu_idx      = w_offset[AW-1:0];

    // ------------------------------------------------------------------
    // Ownership state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CPU;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cpu_service = 1'b0;
        w_host_own    = 1'b0;
        case (r_state)
            S_CPU: begin
                w_cpu_service = 1'b1;
                if (host_mode) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            // Once DRAIN is entered, the grant is always given for at least one
            // cycle, even if host_mode has already dropped.
            S_DRAIN: begin
                w_cpu_service = 1'b1;
                w_state_nxt   = S_HOST;
            end
            S_HOST: begin
                w_host_own = 1'b1;
                if (!host_mode) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_CPU;
            end
            default: begin
                w_state_nxt = S_CPU;
            end
        endcase
    end

    // The reset term keeps the RAM contents unchanged through a reset cycle.
    // The CPU may write only while it is serviced and in range. Any other CPU
    // write is discarded and flagged.
    assign w_cpu_write  = !reset && w_cpu_service && wr_enable && w_cpu_in_range;
    assign w_err_set    = wr_enable && !(w_cpu_service && w_cpu_in_range);
    assign w_host_write = !reset && w_host_own && host_req && host_we;
    assign w_host_read  = w_host_own && host_req && !host_we;

    // ------------------------------------------------------------------
    // RAM array: not reset, one write per cycle (owners are exclusive)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_cpu_write) begin
            r_mem[w_cpu_idx] <= cpu_data;
        end else if (w_host_write) begin
            r_mem[host_addr] <= host_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read data and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_data   <= '0;
            r_host_rdata <= '0;
            r_host_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // The read samples the pre-edge contents, so a write in the same
            // cycle returns the old word.
            if (w_cpu_service && w_cpu_in_range) begin
                r_mem_data <= r_mem[w_cpu_idx];
            end else begin
                r_mem_data <= '0;
            end

            r_host_valid <= w_host_read;
            if (w_host_read) begin
                r_host_rdata <= r_mem[host_addr];
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_data   = r_mem_data;
    assign host_rdata = r_host_rdata;
    assign host_valid = r_host_valid;
    assign err        = r_err;
    assign host_gnt   = w_host_own;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench for data_mem_responder. A behavioural
//                model holds an array image of the RAM, the sticky error bit
//                and the expected read results. Each scenario task drives the
//                inputs and checks the outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int          AW_T   = 10;
    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE_T = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_enable;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;
    logic [31:0] mem_data;
    logic        host_mode;
    logic        host_gnt;
    logic        host_req;
    logic        host_we;
    logic [9:0]  host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_valid;
    logic        err;

    logic [31:0] model_mem [DEPTH];
    logic        model_err;
    int          n_cmp = 0;
    int          n_bad = 0;

    data_mem_responder #(.AW(AW_T), .BASE(BASE_T)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_enable  (wr_enable),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .mem_data   (mem_data),
        .host_mode  (host_mode),
        .host_gnt   (host_gnt),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_valid (host_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_enable  = 1'b0;
        cpu_data   = '0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        host_mode = 1'b0;
        cpu_addr  = BASE_T;
        idle_inputs();
        model_err = 1'b0;
        cyc();
        cyc();
        n_cmp++; if (mem_data !== 32'h0) begin n_bad++; $display("FAIL reset_mem_data: got %h want 0", mem_data); end
        n_cmp++; if (host_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_host_rdata: got %h want 0", host_rdata); end
        n_cmp++; if (host_valid !== 1'b0) begin n_bad++; $display("FAIL reset_host_valid: got %b want 0", host_valid); end
        n_cmp++; if (host_gnt !== 1'b0) begin n_bad++; $display("FAIL reset_host_gnt: got %b want 0", host_gnt); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        reset = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            wr_enable    = 1'b1;
            cpu_addr     = BASE_T + 32'(i);
            cpu_data     = $urandom;
            model_mem[i] = cpu_data;
            cyc();
        end
        idle_inputs();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL fill_err: got %b want 0", err); end
    endtask

    task automatic test_cpu_basic();
        logic [31:0] exp_old;
        exp_old   = model_mem[5];
        wr_enable = 1'b1; cpu_addr = BASE_T + 32'd5; cpu_data = 32'hDEAD_BEEF;
        cyc();
        model_mem[5] = 32'hDEAD_BEEF;
        n_cmp++; if (mem_data !== exp_old) begin n_bad++; $display("FAIL basic_write_old: got %h want %h", mem_data, exp_old); end
        wr_enable = 1'b0;
        cyc();
        n_cmp++; if (mem_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL basic_readback: got %h want deadbeef", mem_data); end
    endtask

    task automatic test_read_before_write();
        wr_enable = 1'b1; cpu_addr = BASE_T + 32'd3; cpu_data = 32'h11;
        cyc();
        model_mem[3] = 32'h11;
        cpu_data = 32'h22;
        cyc();
        n_cmp++; if (mem_data !== 32'h11) begin n_bad++; $display("FAIL rbw_old_word: got %h want 11", mem_data); end
        model_mem[3] = 32'h22;
        wr_enable = 1'b0;
        cyc();
        n_cmp++; if (mem_data !== 32'h22) begin n_bad++; $display("FAIL rbw_new_word: got %h want 22", mem_data); end
    endtask

    task automatic test_out_of_range();
        wr_enable = 1'b0; cpu_addr = BASE_T + 32'(DEPTH);
        cyc();
        n_cmp++; if (mem_data !== 32'h0) begin n_bad++; $display("FAIL oor_read_high: got %h want 0", mem_data); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL oor_read_no_err: got %b want 0", err); end
        cpu_addr = BASE_T - 32'd1;
        cyc();
        n_cmp++; if (mem_data !== 32'h0) begin n_bad++; $display("FAIL oor_read_low: got %h want 0", mem_data); end
        wr_enable = 1'b1; cpu_addr = BASE_T + 32'(DEPTH); cpu_data = 32'h1234_5678;
        cyc();
        model_err = 1'b1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_write_err: got %b want 1", err); end
        wr_enable = 1'b0; cpu_addr = BASE_T;
        cyc();
        n_cmp++; if (mem_data !== model_mem[0]) begin n_bad++; $display("FAIL oor_no_alias: got %h want %h", mem_data, model_mem[0]); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_err_sticky: got %b want 1", err); end
        end
        reset = 1'b1; cpu_addr = BASE_T + 32'd5;
        cyc();
        model_err = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL oor_err_cleared: got %b want 0", err); end
        reset = 1'b0;
        cyc();
        n_cmp++; if (mem_data !== model_mem[5]) begin n_bad++; $display("FAIL ram_kept_over_reset: got %h want %h", mem_data, model_mem[5]); end
    endtask

    task automatic test_cpu_random();
        longint unsigned a;
        bit              in_range;
        logic [31:0]     exp;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       cpu_addr = BASE_T + 32'(DEPTH) + 32'($urandom_range(0, 40));
                1:       cpu_addr = 32'($urandom_range(0, 32'h0FFF));
                2:       cpu_addr = $urandom;
                default: cpu_addr = BASE_T + 32'($urandom_range(0, DEPTH - 1));
            endcase
            wr_enable = 1'($urandom_range(0, 1));
            cpu_data  = $urandom;
            a         = 64'(cpu_addr);
            in_range  = (a >= 64'(BASE_T)) && (a - 64'(BASE_T) < 64'(DEPTH));
            exp       = in_range ? model_mem[int'(a - 64'(BASE_T))] : 32'h0;
            if (wr_enable) begin
                if (in_range) model_mem[int'(a - 64'(BASE_T))] = cpu_data;
                else          model_err = 1'b1;
            end
            cyc();
            n_cmp++; if (mem_data !== exp) begin n_bad++; $display("FAIL cpu_rand_data addr=%h: got %h want %h", cpu_addr, mem_data, exp); end
            n_cmp++; if (err !== model_err) begin n_bad++; $display("FAIL cpu_rand_err addr=%h: got %b want %b", cpu_addr, err, model_err); end
        end
        idle_inputs();
    endtask

    task automatic apply_reset();
        idle_inputs();
        host_mode = 1'b0;
        reset     = 1'b1;
        cyc();
        reset     = 1'b0;
        model_err = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL apply_reset_err: got %b want 0", err); end
    endtask

    task automatic test_host();
        logic [31:0] v21;
        logic [31:0] exp;
        bit          rd;
        // Host requests are ignored while the CPU owns the RAM.
        cpu_addr = BASE_T + 32'd9;
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'd9; host_wdata = ~model_mem[9];
        cyc();
        n_cmp++; if (host_valid !== 1'b0) begin n_bad++; $display("FAIL idle_host_write_valid: got %b want 0", host_valid); end
        host_we = 1'b0;
        cyc();
        n_cmp++; if (host_valid !== 1'b0) begin n_bad++; $display("FAIL idle_host_read_valid: got %b want 0", host_valid); end
        idle_inputs();
        cyc();
        n_cmp++; if (mem_data !== model_mem[9]) begin n_bad++; $display("FAIL idle_host_no_effect: got %h want %h", mem_data, model_mem[9]); end

        // Request ownership; DRAIN still serves the CPU.
        host_mode = 1'b1; cpu_addr = BASE_T + 32'd20;
        cyc();
        n_cmp++; if (host_gnt !== 1'b0) begin n_bad++; $display("FAIL gnt_after_1: got %b want 0", host_gnt); end
        n_cmp++; if (mem_data !== model_mem[20]) begin n_bad++; $display("FAIL drain_prev_read: got %h want %h", mem_data, model_mem[20]); end
        v21 = $urandom;
        wr_enable = 1'b1; cpu_addr = BASE_T + 32'd21; cpu_data = v21;
        exp = model_mem[21];
        cyc();
        model_mem[21] = v21;
        n_cmp++; if (host_gnt !== 1'b1) begin n_bad++; $display("FAIL gnt_after_2: got %b want 1", host_gnt); end
        n_cmp++; if (mem_data !== exp) begin n_bad++; $display("FAIL drain_cpu_read: got %h want %h", mem_data, exp); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL drain_write_no_err: got %b want 0", err); end
        wr_enable = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'd7; host_wdata = 32'hA5;
        cyc();
        model_mem[7] = 32'hA5;
        n_cmp++; if (host_valid !== 1'b0) begin n_bad++; $display("FAIL host_write_valid: got %b want 0", host_valid); end
        n_cmp++; if (mem_data !== 32'h0) begin n_bad++; $display("FAIL host_mem_data_zero: got %h want 0", mem_data); end
        host_we = 1'b0;
        cyc();
        n_cmp++; if (host_valid !== 1'b1 || host_rdata !== 32'hA5) begin n_bad++; $display("FAIL host_read7: got v=%b d=%h want v=1 d=a5", host_valid, host_rdata); end
        host_addr = 10'd21;
        cyc();
        n_cmp++; if (host_valid !== 1'b1 || host_rdata !== v21) begin n_bad++; $display("FAIL host_b2b_read21: got v=%b d=%h want v=1 d=%h", host_valid, host_rdata, v21); end
        host_req = 1'b0;
        cyc();
        n_cmp++; if (host_valid !== 1'b0) begin n_bad++; $display("FAIL host_valid_pulse: got %b want 0", host_valid); end
        wr_enable = 1'b1; cpu_addr = BASE_T + 32'd7; cpu_data = 32'h0BAD;
        cyc();
        model_err = 1'b1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL host_cpu_write_err: got %b want 1", err); end
        wr_enable = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'd7;
        cyc();
        n_cmp++; if (host_rdata !== 32'hA5) begin n_bad++; $display("FAIL host_cpu_write_discard: got %h want a5", host_rdata); end
        host_addr = 10'd9;
        cyc();
        n_cmp++; if (host_rdata !== model_mem[9]) begin n_bad++; $display("FAIL idle_host_write_discard: got %h want %h", host_rdata, model_mem[9]); end

        // Random host traffic over a small address window.
        for (int n = 0; n < 150; n++) begin
            host_req   = 1'($urandom_range(0, 1));
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = 10'($urandom_range(0, 15));
            host_wdata = $urandom;
            rd  = host_req && !host_we;
            exp = model_mem[host_addr];
            if (host_req && host_we) model_mem[host_addr] = host_wdata;
            cyc();
            n_cmp++; if (host_valid !== 1'(rd)) begin n_bad++; $display("FAIL host_rand_valid: got %b want %b", host_valid, rd); end
            if (rd) begin
                n_cmp++; if (host_rdata !== exp) begin n_bad++; $display("FAIL host_rand_rdata: got %h want %h", host_rdata, exp); end
            end
            n_cmp++; if (host_gnt !== 1'b1 || mem_data !== 32'h0) begin n_bad++; $display("FAIL host_rand_own: got gnt=%b md=%h want 1/0", host_gnt, mem_data); end
        end
        idle_inputs();
    endtask

    task automatic test_release();
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'd7; host_wdata = 32'hA5;
        cyc();
        model_mem[7] = 32'hA5;
        host_mode = 1'b0; host_we = 1'b0;
        cyc();
        n_cmp++; if (host_valid !== 1'b1 || host_rdata !== 32'hA5) begin n_bad++; $display("FAIL release_read: got v=%b d=%h want v=1 d=a5", host_valid, host_rdata); end
        n_cmp++; if (host_gnt !== 1'b0) begin n_bad++; $display("FAIL release_gnt: got %b want 0", host_gnt); end
        idle_inputs();
        cpu_addr = BASE_T + 32'd7;
        cyc();
        n_cmp++; if (host_valid !== 1'b0) begin n_bad++; $display("FAIL release_valid_drop: got %b want 0", host_valid); end
        cyc();
        n_cmp++; if (mem_data !== 32'hA5) begin n_bad++; $display("FAIL release_cpu_read7: got %h want a5", mem_data); end
        n_cmp++; if (err !== model_err) begin n_bad++; $display("FAIL release_err_sticky: got %b want %b", err, model_err); end
    endtask

    task automatic test_drain_abort();
        cpu_addr = BASE_T + 32'd30;
        host_mode = 1'b1;
        cyc();
        host_mode = 1'b0;
        n_cmp++; if (host_gnt !== 1'b0) begin n_bad++; $display("FAIL abort_gnt_drain: got %b want 0", host_gnt); end
        cyc();
        n_cmp++; if (host_gnt !== 1'b1) begin n_bad++; $display("FAIL abort_gnt_host: got %b want 1", host_gnt); end
        cyc();
        n_cmp++; if (host_gnt !== 1'b0) begin n_bad++; $display("FAIL abort_gnt_release: got %b want 0", host_gnt); end
        cyc();
        cyc();
        n_cmp++; if (host_gnt !== 1'b0 || mem_data !== model_mem[30]) begin n_bad++; $display("FAIL abort_back_to_cpu: got gnt=%b md=%h want 0/%h", host_gnt, mem_data, model_mem[30]); end
    endtask

    task automatic test_reset_mid_host();
        host_mode = 1'b1;
        cyc();
        cyc();
        n_cmp++; if (host_gnt !== 1'b1) begin n_bad++; $display("FAIL rst_host_entry: got %b want 1", host_gnt); end
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'd7;
        reset = 1'b1;
        cyc();
        model_err = 1'b0;
        n_cmp++; if (host_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pending_valid: got %b want 0", host_valid); end
        n_cmp++; if (host_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_gnt: got %b want 0", host_gnt); end
        n_cmp++; if (host_rdata !== 32'h0 || mem_data !== 32'h0) begin n_bad++; $display("FAIL rst_data: got hr=%h md=%h want 0/0", host_rdata, mem_data); end
        reset = 1'b0; host_mode = 1'b0;
        idle_inputs();
        cpu_addr = BASE_T + 32'd7;
        cyc();
        n_cmp++; if (mem_data !== 32'hA5 || host_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_ram_kept: got md=%h gnt=%b want a5/0", mem_data, host_gnt); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_cpu_basic();
        test_read_before_write();
        test_out_of_range();
        test_cpu_random();
        apply_reset();
        test_host();
        test_release();
        apply_reset();
        test_drain_abort();
        test_reset_mid_host();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
